// File: rtl/v_pipe_update_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : v_pipe_update_mc                                                 |
// | Brief   : Multi-channel sorted key/volume table engine. Executes           |
// |           CLEAR/ADD/DELETE/REPLACE against CHANNELS_N independent sorted   |
// |           tables through one EXE stage and a registered response.          |
// |           Optional macro V_PIPE_UPDATE_MC_STATS_EN adds o_err_cnt.         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module v_pipe_update_mc #(
  parameter  int ENTRIES_N  = 16,
  parameter  int CHANNELS_N = 4,
  parameter  int KEY_W      = 32,
  parameter  int VOLUME_W   = 16,
  localparam int CH_W       = (CHANNELS_N > 1) ? $clog2(CHANNELS_N) : 1,
  localparam int CNT_W      = $clog2(ENTRIES_N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef V_PIPE_UPDATE_MC_STATS_EN
  output logic [15:0]         o_err_cnt,
`endif
  input  logic                i_cmd_vld,
  output logic                o_cmd_rdy,
  input  logic [2:0]          i_cmd_op,
  input  logic [CH_W-1:0]     i_cmd_ch,
  input  logic [KEY_W-1:0]    i_cmd_key,
  input  logic [VOLUME_W-1:0] i_cmd_volume,
  output logic                o_rsp_vld,
  input  logic                i_rsp_rdy,
  output logic [CH_W-1:0]     o_rsp_ch,
  output logic [1:0]          o_rsp_status,
  output logic [CNT_W-1:0]    o_rsp_count,
  output logic [KEY_W-1:0]    o_rsp_head_key,
  output logic [VOLUME_W-1:0] o_rsp_head_vol
);

  localparam int IDX_W = $clog2(ENTRIES_N);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CLEAR   = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_DELETE  = 3'd3;
  localparam logic [2:0] OP_REPLACE = 3'd4;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_NF   = 2'd2;
  localparam logic [1:0] ST_ILL  = 2'd3;

  // table storage
  logic [KEY_W-1:0]    key_q [CHANNELS_N][ENTRIES_N];
  logic [KEY_W-1:0]    key_d [CHANNELS_N][ENTRIES_N];
  logic [VOLUME_W-1:0] vol_q [CHANNELS_N][ENTRIES_N];
  logic [VOLUME_W-1:0] vol_d [CHANNELS_N][ENTRIES_N];
  logic [ENTRIES_N-1:0] vld_q [CHANNELS_N];
  logic [ENTRIES_N-1:0] vld_d [CHANNELS_N];
  logic [CNT_W-1:0]    cnt_q [CHANNELS_N];
  logic [CNT_W-1:0]    cnt_d [CHANNELS_N];

  // EXE stage
  logic                exe_vld_q, exe_vld_d;
  logic [2:0]          exe_op_q, exe_op_d;
  logic [CH_W-1:0]     exe_ch_q, exe_ch_d;
  logic [KEY_W-1:0]    exe_key_q, exe_key_d;
  logic [VOLUME_W-1:0] exe_vol_q, exe_vol_d;

  // response registers
  logic                rsp_vld_q, rsp_vld_d;
  logic [CH_W-1:0]     rsp_ch_q, rsp_ch_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [CNT_W-1:0]    rsp_count_q, rsp_count_d;
  logic [KEY_W-1:0]    rsp_head_key_q, rsp_head_key_d;
  logic [VOLUME_W-1:0] rsp_head_vol_q, rsp_head_vol_d;

  // evaluation of the EXE command against the selected channel row
  logic [KEY_W-1:0]    row_key [ENTRIES_N];
  logic [VOLUME_W-1:0] row_vol [ENTRIES_N];
  logic [ENTRIES_N-1:0] row_vld;
  logic [CNT_W-1:0]    row_cnt;
  logic [KEY_W-1:0]    new_key [ENTRIES_N];
  logic [VOLUME_W-1:0] new_vol [ENTRIES_N];
  logic [ENTRIES_N-1:0] new_vld;
  logic [CNT_W-1:0]    new_cnt;
  logic                hit, ch_ok, wr_en;
  logic [IDX_W-1:0]    hit_idx;
  logic [CNT_W-1:0]    ins_idx;
  logic [1:0]          ev_status;
  logic [KEY_W-1:0]    ev_head_key;
  logic [VOLUME_W-1:0] ev_head_vol;

  logic stall, retire, accept;

  // a full response register that is not being taken blocks the EXE stage
  assign stall     = rsp_vld_q & ~i_rsp_rdy;
  assign retire    = exe_vld_q & ~stall;
  assign o_cmd_rdy = ~exe_vld_q | ~stall;
  assign accept    = i_cmd_vld & o_cmd_rdy;

  // EXE stage load / drain
  always_comb begin
    exe_vld_d = exe_vld_q;
    exe_op_d  = exe_op_q;
    exe_ch_d  = exe_ch_q;
    exe_key_d = exe_key_q;
    exe_vol_d = exe_vol_q;
    if (accept) begin
      exe_vld_d = 1'b1;
      exe_op_d  = i_cmd_op;
      exe_ch_d  = i_cmd_ch;
      exe_key_d = i_cmd_key;
      exe_vol_d = i_cmd_volume;
    end else if (retire) begin
      exe_vld_d = 1'b0;
    end
  end

  // execute the command on a copy of the target row; keys stay sorted and packed
  always_comb begin
    row_key = key_q[exe_ch_q];
    row_vol = vol_q[exe_ch_q];
    row_vld = vld_q[exe_ch_q];
    row_cnt = cnt_q[exe_ch_q];
    ch_ok   = (int'(exe_ch_q) < CHANNELS_N);

    hit     = 1'b0;
    hit_idx = '0;
    ins_idx = row_cnt;
    for (int i = ENTRIES_N - 1; i >= 0; i--) begin
      if (row_vld[i] && (row_key[i] == exe_key_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (row_vld[i] && (row_key[i] > exe_key_q)) begin
        ins_idx = CNT_W'(i);
      end
    end

    new_key   = row_key;
    new_vol   = row_vol;
    new_vld   = row_vld;
    new_cnt   = row_cnt;
    ev_status = ST_OK;
    wr_en     = 1'b0;

    if (!ch_ok) begin
      ev_status = ST_ILL;
      new_cnt   = '0;
    end else begin
      case (exe_op_q)
        OP_NOP: ;
        OP_CLEAR: begin
          new_vld = '0;
          new_cnt = '0;
          wr_en   = 1'b1;
        end
        OP_ADD: begin
          if (hit) begin
            ev_status = ST_ILL;
          end else if (int'(row_cnt) == ENTRIES_N) begin
            ev_status = ST_FULL;
          end else begin
            wr_en   = 1'b1;
            new_cnt = row_cnt + CNT_W'(1);
            for (int i = 0; i < ENTRIES_N; i++) begin
              if (i == int'(ins_idx)) begin
                new_key[i] = exe_key_q;
                new_vol[i] = exe_vol_q;
              end else if (i > int'(ins_idx)) begin
                new_key[i] = row_key[(i > 0) ? i - 1 : 0];
                new_vol[i] = row_vol[(i > 0) ? i - 1 : 0];
              end
              new_vld[i] = (i < int'(new_cnt));
            end
          end
        end
        OP_DELETE: begin
          if (!hit) begin
            ev_status = ST_NF;
          end else begin
            wr_en   = 1'b1;
            new_cnt = row_cnt - CNT_W'(1);
            for (int i = 0; i < ENTRIES_N; i++) begin
              if (i >= int'(hit_idx)) begin
                if (i == ENTRIES_N - 1) begin
                  new_key[i] = '0;
                  new_vol[i] = '0;
                end else begin
                  new_key[i] = row_key[(i < ENTRIES_N - 1) ? i + 1 : i];
                  new_vol[i] = row_vol[(i < ENTRIES_N - 1) ? i + 1 : i];
                end
              end
              new_vld[i] = (i < int'(new_cnt));
            end
          end
        end
        OP_REPLACE: begin
          if (!hit) begin
            ev_status = ST_NF;
          end else begin
            wr_en            = 1'b1;
            new_vol[hit_idx] = exe_vol_q;
          end
        end
        default: ev_status = ST_ILL;
      endcase
    end

    ev_head_key = (new_cnt != '0) ? new_key[0] : '0;
    ev_head_vol = (new_cnt != '0) ? new_vol[0] : '0;
  end

  // commit the updated row when the EXE command retires
  always_comb begin
    key_d = key_q;
    vol_d = vol_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (retire && wr_en) begin
      key_d[exe_ch_q] = new_key;
      vol_d[exe_ch_q] = new_vol;
      vld_d[exe_ch_q] = new_vld;
      cnt_d[exe_ch_q] = new_cnt;
    end
  end

  // response register: loads on retire, clears on handshake, otherwise holds
  always_comb begin
    rsp_vld_d      = rsp_vld_q;
    rsp_ch_d       = rsp_ch_q;
    rsp_status_d   = rsp_status_q;
    rsp_count_d    = rsp_count_q;
    rsp_head_key_d = rsp_head_key_q;
    rsp_head_vol_d = rsp_head_vol_q;
    if (retire) begin
      rsp_vld_d      = 1'b1;
      rsp_ch_d       = exe_ch_q;
      rsp_status_d   = ev_status;
      rsp_count_d    = new_cnt;
      rsp_head_key_d = ev_head_key;
      rsp_head_vol_d = ev_head_vol;
    end else if (rsp_vld_q && i_rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  // state registers; reset drops any in-flight command and pending response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS_N; c++) begin
        vld_q[c] <= '0;
        cnt_q[c] <= '0;
        for (int e = 0; e < ENTRIES_N; e++) begin
          key_q[c][e] <= '0;
          vol_q[c][e] <= '0;
        end
      end
      exe_vld_q      <= 1'b0;
      exe_op_q       <= '0;
      exe_ch_q       <= '0;
      exe_key_q      <= '0;
      exe_vol_q      <= '0;
      rsp_vld_q      <= 1'b0;
      rsp_ch_q       <= '0;
      rsp_status_q   <= '0;
      rsp_count_q    <= '0;
      rsp_head_key_q <= '0;
      rsp_head_vol_q <= '0;
    end else begin
      key_q          <= key_d;
      vol_q          <= vol_d;
      vld_q          <= vld_d;
      cnt_q          <= cnt_d;
      exe_vld_q      <= exe_vld_d;
      exe_op_q       <= exe_op_d;
      exe_ch_q       <= exe_ch_d;
      exe_key_q      <= exe_key_d;
      exe_vol_q      <= exe_vol_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_ch_q       <= rsp_ch_d;
      rsp_status_q   <= rsp_status_d;
      rsp_count_q    <= rsp_count_d;
      rsp_head_key_q <= rsp_head_key_d;
      rsp_head_vol_q <= rsp_head_vol_d;
    end
  end

  assign o_rsp_vld      = rsp_vld_q;
  assign o_rsp_ch       = rsp_ch_q;
  assign o_rsp_status   = rsp_status_q;
  assign o_rsp_count    = rsp_count_q;
  assign o_rsp_head_key = rsp_head_key_q;
  assign o_rsp_head_vol = rsp_head_vol_q;

`ifdef V_PIPE_UPDATE_MC_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // count non-OK responses as they are written, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (retire && (ev_status != ST_OK) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // error counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_v_pipe_update_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_v_pipe_update_mc                                              |
// | Brief   : Directed self-checking bench for v_pipe_update_mc.               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_v_pipe_update_mc;

  localparam int CH_W  = 2;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CLEAR   = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_DELETE  = 3'd3;
  localparam logic [2:0] OP_REPLACE = 3'd4;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_NF   = 2'd2;
  localparam logic [1:0] ST_ILL  = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_cmd_vld;
  logic             o_cmd_rdy;
  logic [2:0]       i_cmd_op;
  logic [CH_W-1:0]  i_cmd_ch;
  logic [31:0]      i_cmd_key;
  logic [15:0]      i_cmd_volume;
  logic             o_rsp_vld;
  logic             i_rsp_rdy;
  logic [CH_W-1:0]  o_rsp_ch;
  logic [1:0]       o_rsp_status;
  logic [CNT_W-1:0] o_rsp_count;
  logic [31:0]      o_rsp_head_key;
  logic [15:0]      o_rsp_head_vol;
`ifdef V_PIPE_UPDATE_MC_STATS_EN
  logic [15:0]      o_err_cnt;
`endif

  v_pipe_update_mc dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef V_PIPE_UPDATE_MC_STATS_EN
    .o_err_cnt      (o_err_cnt),
`endif
    .i_cmd_vld      (i_cmd_vld),
    .o_cmd_rdy      (o_cmd_rdy),
    .i_cmd_op       (i_cmd_op),
    .i_cmd_ch       (i_cmd_ch),
    .i_cmd_key      (i_cmd_key),
    .i_cmd_volume   (i_cmd_volume),
    .o_rsp_vld      (o_rsp_vld),
    .i_rsp_rdy      (i_rsp_rdy),
    .o_rsp_ch       (o_rsp_ch),
    .o_rsp_status   (o_rsp_status),
    .o_rsp_count    (o_rsp_count),
    .o_rsp_head_key (o_rsp_head_key),
    .o_rsp_head_vol (o_rsp_head_vol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    int          cnt;
    logic [31:0] hk;
    logic [15:0] hv;
    int          ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input int ch, input logic [1:0] st, input int cnt,
                          input logic [31:0] hk, input logic [15:0] hv);
    exp_t e;
    e.ch = ch; e.st = st; e.cnt = cnt; e.hk = hk; e.hv = hv;
    exp_q.push_back(e);
  endtask

  // called at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic [2:0] op, input int ch, input logic [31:0] key,
                       input logic [15:0] vol, input logic [1:0] st, input int cnt,
                       input logic [31:0] hk, input logic [15:0] hv);
    bit acc;
    int n;
    push_exp(ch, st, cnt, hk, hv);
    i_cmd_vld    = 1'b1;
    i_cmd_op     = op;
    i_cmd_ch     = CH_W'(ch);
    i_cmd_key    = key;
    i_cmd_volume = vol;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      #1;
      acc = o_cmd_rdy;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!acc) chk("cmd_accept_timeout", 64'(acc), 64'd1);
    i_cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // response checker against the expected queue
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && o_rsp_vld && i_rsp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(o_rsp_vld), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_ch",       64'(o_rsp_ch),       64'(e.ch));
        chk("rsp_status",   64'(o_rsp_status),   64'(e.st));
        chk("rsp_count",    64'(o_rsp_count),    64'(e.cnt));
        chk("rsp_head_key", 64'(o_rsp_head_key), 64'(e.hk));
        chk("rsp_head_vol", 64'(o_rsp_head_vol), 64'(e.hv));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_cmd_vld = 1'b0; i_cmd_op = '0; i_cmd_ch = '0;
    i_cmd_key = '0; i_cmd_volume = '0; i_rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rsp_vld",  64'(o_rsp_vld),      64'd0);
    chk("rst_cmd_rdy",  64'(o_cmd_rdy),      64'd1);
    chk("rst_status",   64'(o_rsp_status),   64'd0);
    chk("rst_count",    64'(o_rsp_count),    64'd0);
    chk("rst_head_key", 64'(o_rsp_head_key), 64'd0);
    chk("rst_head_vol", 64'(o_rsp_head_vol), 64'd0);
`ifdef V_PIPE_UPDATE_MC_STATS_EN
    chk("rst_err_cnt",  64'(o_err_cnt),      64'd0);
`endif
    @(negedge clk);

    // sorted insert on ch0
    issue(OP_ADD, 0, 32'd30, 16'd3, ST_OK, 1, 32'd30, 16'd3);
    issue(OP_ADD, 0, 32'd10, 16'd1, ST_OK, 2, 32'd10, 16'd1);
    issue(OP_ADD, 0, 32'd20, 16'd2, ST_OK, 3, 32'd10, 16'd1);
    drain();

    // fill ch1, overflow, delete head
    for (int k = 1; k <= 16; k++)
      issue(OP_ADD, 1, 32'(k), 16'(k), ST_OK, k, 32'd1, 16'd1);
    issue(OP_ADD,    1, 32'd99, 16'd9, ST_FULL, 16, 32'd1, 16'd1);
    issue(OP_DELETE, 1, 32'd1,  16'd0, ST_OK,   15, 32'd2, 16'd2);
    issue(OP_ADD,    1, 32'd50, 16'd7, ST_OK,   16, 32'd2, 16'd2);
    drain();

    // duplicate, miss, replace, illegal op, clear, stale-slot miss
    issue(OP_ADD,     2, 32'd5, 16'h11, ST_OK,  1, 32'd5, 16'h11);
    issue(OP_ADD,     2, 32'd5, 16'h22, ST_ILL, 1, 32'd5, 16'h11);
    issue(OP_DELETE,  2, 32'd7, 16'h00, ST_NF,  1, 32'd5, 16'h11);
    issue(OP_REPLACE, 2, 32'd5, 16'hAB, ST_OK,  1, 32'd5, 16'hAB);
    issue(3'd6,       2, 32'd5, 16'h00, ST_ILL, 1, 32'd5, 16'hAB);
    issue(OP_CLEAR,   2, 32'd0, 16'h00, ST_OK,  0, 32'd0, 16'h00);
    issue(OP_DELETE,  2, 32'd5, 16'h00, ST_NF,  0, 32'd0, 16'h00);
    issue(OP_NOP,     0, 32'd0, 16'h00, ST_OK,  3, 32'd10, 16'd1);
    drain();

    // backpressure: two accepted, third held off, response stable
    i_rsp_rdy = 1'b0;
    i_cmd_vld = 1'b1; i_cmd_op = OP_ADD; i_cmd_ch = 2'd3;
    i_cmd_key = 32'd40; i_cmd_volume = 16'd4;
    #1; chk("bp_rdy_a", 64'(o_cmd_rdy), 64'd1);
    @(posedge clk); @(negedge clk);
    i_cmd_key = 32'd50; i_cmd_volume = 16'd5;
    #1; chk("bp_rdy_b", 64'(o_cmd_rdy), 64'd1);
    @(posedge clk); @(negedge clk);
    i_cmd_key = 32'd45; i_cmd_volume = 16'd6;
    #1;
    chk("bp_rdy_c",   64'(o_cmd_rdy),      64'd0);
    chk("bp_rsp_vld", 64'(o_rsp_vld),      64'd1);
    chk("bp_count",   64'(o_rsp_count),    64'd1);
    chk("bp_head_key",64'(o_rsp_head_key), 64'd40);
    repeat (3) begin
      @(negedge clk); #1;
      chk("bp_hold_rdy",      64'(o_cmd_rdy),      64'd0);
      chk("bp_hold_vld",      64'(o_rsp_vld),      64'd1);
      chk("bp_hold_count",    64'(o_rsp_count),    64'd1);
      chk("bp_hold_head_key", 64'(o_rsp_head_key), 64'd40);
      chk("bp_hold_head_vol", 64'(o_rsp_head_vol), 64'd4);
    end
    push_exp(3, ST_OK, 1, 32'd40, 16'd4);
    push_exp(3, ST_OK, 2, 32'd40, 16'd4);
    @(negedge clk);
    i_rsp_rdy = 1'b1;
    issue(OP_ADD, 3, 32'd45, 16'd6, ST_OK, 3, 32'd40, 16'd4);
    drain();

    // reset while a command is in flight
    i_cmd_vld = 1'b1; i_cmd_op = OP_ADD; i_cmd_ch = 2'd0;
    i_cmd_key = 32'd8; i_cmd_volume = 16'd8;
    @(posedge clk); @(negedge clk);
    i_cmd_vld = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_rsp_vld", 64'(o_rsp_vld),   64'd0);
    chk("mrst_count",   64'(o_rsp_count), 64'd0);
`ifdef V_PIPE_UPDATE_MC_STATS_EN
    chk("mrst_err_cnt", 64'(o_err_cnt),   64'd0);
`endif
    @(negedge clk);
    issue(OP_NOP, 0, 32'd0, 16'd0, ST_OK, 0, 32'd0, 16'd0);
    issue(OP_NOP, 3, 32'd0, 16'd0, ST_OK, 0, 32'd0, 16'd0);
    drain();

    // back-to-back interleaved ch0/ch3 traffic
    issue(OP_ADD,    0, 32'd50, 16'd1, ST_OK, 1, 32'd50, 16'd1);
    issue(OP_ADD,    3, 32'd7,  16'd2, ST_OK, 1, 32'd7,  16'd2);
    issue(OP_ADD,    0, 32'd20, 16'd3, ST_OK, 2, 32'd20, 16'd3);
    issue(OP_ADD,    3, 32'd3,  16'd4, ST_OK, 2, 32'd3,  16'd4);
    issue(OP_DELETE, 0, 32'd20, 16'd0, ST_OK, 1, 32'd50, 16'd1);
    issue(OP_DELETE, 3, 32'd7,  16'd0, ST_OK, 1, 32'd3,  16'd4);
    issue(OP_ADD,    0, 32'd60, 16'd5, ST_OK, 2, 32'd50, 16'd1);
    issue(OP_DELETE, 3, 32'd3,  16'd0, ST_OK, 0, 32'd0,  16'd0);
    issue(OP_DELETE, 0, 32'd50, 16'd0, ST_OK, 1, 32'd60, 16'd5);
    issue(OP_DELETE, 3, 32'd3,  16'd0, ST_NF, 0, 32'd0,  16'd0);
    issue(OP_ADD,    0, 32'd55, 16'd6, ST_OK, 2, 32'd55, 16'd6);
    issue(OP_DELETE, 0, 32'd55, 16'd0, ST_OK, 1, 32'd60, 16'd5);
    issue(OP_ADD,    0, 32'd70, 16'd9, ST_OK, 2, 32'd60, 16'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
